// File: rtl/sobel_gradient.sv
// 3x3 Sobel gradient stage: two line buffers plus a sliding window over a raster pixel stream,
// emitting saturated |Gx| and |Gy| for every interior pixel through a single output register.
module sobel_gradient #(
  parameter int WIDTH_P   = 8,
  parameter int LINE_W_P  = 640,
  parameter int FRAME_H_P = 480
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic               sof_i,
  input  logic [WIDTH_P-1:0] data_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [WIDTH_P-1:0] gx_o,
  output logic [WIDTH_P-1:0] gy_o
);

  localparam int COL_W = (LINE_W_P > 1) ? $clog2(LINE_W_P) : 1;
  localparam int ROW_W = (FRAME_H_P > 1) ? $clog2(FRAME_H_P) : 1;
  localparam int G_W   = WIDTH_P + 3;

  // Handshake: a beat transfers on a rising edge where valid and ready are both high.
  // valid_o/gx_o/gy_o stay stable while valid_o & ~ready_i; ready_o never depends on valid_i.
  logic acc;
  logic gate;

  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] pos_col;
  logic [ROW_W-1:0] pos_row;

  logic [WIDTH_P-1:0] lb0 [LINE_W_P];
  logic [WIDTH_P-1:0] lb1 [LINE_W_P];

  logic [WIDTH_P-1:0] win_q [3][3];
  logic [WIDTH_P-1:0] win_d [3][3];

  logic signed [G_W-1:0] gx_s;
  logic signed [G_W-1:0] gy_s;

  assign ready_o = ~valid_o | ready_i;
  assign acc     = valid_i & ready_o;
  assign pos_col = sof_i ? '0 : col_q;
  assign pos_row = sof_i ? '0 : row_q;
  assign gate    = acc && (pos_row >= ROW_W'(2)) && (pos_col >= COL_W'(2));

  function automatic logic signed [G_W-1:0] ext(input logic [WIDTH_P-1:0] p);
    return $signed({3'b000, p});
  endfunction

  function automatic logic [WIDTH_P-1:0] abs_sat(input logic signed [G_W-1:0] g);
    logic [G_W-1:0] mag;
    mag = g[G_W-1] ? G_W'(-g) : G_W'(g);
    if (|mag[G_W-1:WIDTH_P]) return {WIDTH_P{1'b1}};
    return mag[WIDTH_P-1:0];
  endfunction

  // Window after this cycle's shift; the gradient is taken from this post-shift view.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_d[r][0] = win_q[r][1];
      win_d[r][1] = win_q[r][2];
      win_d[r][2] = '0;
    end
    win_d[0][2] = lb1[pos_col];
    win_d[1][2] = lb0[pos_col];
    win_d[2][2] = data_i;
  end

  always_comb begin
    gx_s = (ext(win_d[0][2]) + (ext(win_d[1][2]) <<< 1) + ext(win_d[2][2]))
         - (ext(win_d[0][0]) + (ext(win_d[1][0]) <<< 1) + ext(win_d[2][0]));
    gy_s = (ext(win_d[2][0]) + (ext(win_d[2][1]) <<< 1) + ext(win_d[2][2]))
         - (ext(win_d[0][0]) + (ext(win_d[0][1]) <<< 1) + ext(win_d[0][2]));
  end

  // Line-buffer RAM is never cleared; stale rows are masked by the row>=2 gate.
  always_ff @(posedge clk_i) begin
    if (acc && rstn_i) begin
      lb1[pos_col] <= lb0[pos_col];
      lb0[pos_col] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_o <= 1'b0;
      gx_o    <= '0;
      gy_o    <= '0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      if (acc) begin
        win_q <= win_d;
        if (pos_col == COL_W'(LINE_W_P - 1)) begin
          col_q <= '0;
          row_q <= (pos_row == ROW_W'(FRAME_H_P - 1)) ? '0 : pos_row + ROW_W'(1);
        end else begin
          col_q <= pos_col + COL_W'(1);
          row_q <= pos_row;
        end
      end
      if (gate) begin
        valid_o <= 1'b1;
        gx_o    <= abs_sat(gx_s);
        gy_o    <= abs_sat(gy_s);
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sobel_gradient.sv
// Bench for sobel_gradient: directed 4x4 frames plus randomized pixels and back-pressure,
// scored against a whole-image Sobel reference.
module tb_sobel_gradient;

  localparam int W  = 8;
  localparam int LW = 4;
  localparam int FH = 4;

  logic         clk_i = 1'b0;
  logic         rstn_i = 1'b0;
  logic         valid_i = 1'b0;
  logic         ready_o;
  logic         sof_i = 1'b0;
  logic [W-1:0] data_i = '0;
  logic         valid_o;
  logic         ready_i = 1'b1;
  logic [W-1:0] gx_o;
  logic [W-1:0] gy_o;

  always #5 clk_i = ~clk_i;

  sobel_gradient #(.WIDTH_P(W), .LINE_W_P(LW), .FRAME_H_P(FH)) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .sof_i  (sof_i),
    .data_i (data_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .gx_o   (gx_o),
    .gy_o   (gy_o)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: full image of the current frame, Sobel taken around (r-1,c-1).
  int               img [FH][LW];
  int               m_row = 0;
  int               m_col = 0;
  logic [2*W-1:0]   exp_q [$];
  int               out_cnt = 0;
  logic             prev_stall = 1'b0;
  logic [W-1:0]     prev_gx, prev_gy;
  logic [W-1:0]     last_gx = '0;
  logic [W-1:0]     last_gy = '0;
  int               rdy_mode = 1;

  function automatic int sat(input int v);
    int a;
    a = (v < 0) ? -v : v;
    return (a > (1 << W) - 1) ? (1 << W) - 1 : a;
  endfunction

  function automatic logic [2*W-1:0] ref_sobel(input int r, input int c);
    int gx, gy, wt;
    logic [W-1:0] a, b;
    gx = 0;
    gy = 0;
    for (int k = 0; k < 3; k++) begin
      wt = (k == 1) ? 2 : 1;
      gx += wt * (img[r-2+k][c] - img[r-2+k][c-2]);
      gy += wt * (img[r][c-2+k] - img[r-2][c-2+k]);
    end
    a = W'(sat(gx));
    b = W'(sat(gy));
    return {a, b};
  endfunction

  always @(posedge clk_i) begin
    #1;
    ready_i = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
  end

  // Scoreboard and reference update, sampled mid-cycle.
  always @(negedge clk_i) begin
    logic [2*W-1:0] e;
    if (!rstn_i) begin
      exp_q.delete();
      prev_stall = 1'b0;
      m_row = 0;
      m_col = 0;
    end else begin
      if (prev_stall) begin
        check("hold_v", valid_o, 1);
        check("hold_gx", gx_o, prev_gx);
        check("hold_gy", gy_o, prev_gy);
      end
      check("ready", ready_o, (!valid_o) || ready_i);
      if (valid_o && ready_i) begin
        check("q_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("gx", gx_o, e[2*W-1:W]);
          check("gy", gy_o, e[W-1:0]);
        end
        out_cnt++;
        last_gx = gx_o;
        last_gy = gy_o;
      end
      prev_stall = valid_o && !ready_i;
      prev_gx = gx_o;
      prev_gy = gy_o;
      if (valid_i && ready_o) begin
        if (sof_i) begin
          m_row = 0;
          m_col = 0;
        end
        img[m_row][m_col] = int'(data_i);
        if (m_row >= 2 && m_col >= 2) exp_q.push_back(ref_sobel(m_row, m_col));
        m_col++;
        if (m_col == LW) begin
          m_col = 0;
          m_row++;
          if (m_row == FH) m_row = 0;
        end
      end
    end
  end

  // Drivers: entered and left at posedge+1.
  task automatic send_pix(input logic [W-1:0] d, input logic s, input int gap);
    int  n;
    logic done;
    n = 0;
    done = 1'b0;
    valid_i = 1'b1;
    data_i  = d;
    sof_i   = s;
    while (!done) begin
      @(negedge clk_i);
      done = ready_o;
      @(posedge clk_i);
      #1;
      n++;
      if (!done && n > 200) begin
        check("stall_timeout", n, 0);
        done = 1'b1;
      end
    end
    valid_i = 1'b0;
    sof_i   = 1'b0;
    repeat (gap) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  function automatic logic [W-1:0] pix(input int mode, input int r, input int c);
    case (mode)
      0:       return W'(100);
      1:       return (c < 2) ? W'(0) : W'(255);
      2:       return (r < 2) ? W'(0) : W'(10);
      default: return W'($urandom_range(0, (1 << W) - 1));
    endcase
  endfunction

  task automatic send_frame(input int mode, input logic use_sof, input logic gaps, input int npix);
    int k;
    k = 0;
    for (int r = 0; r < FH; r++) begin
      for (int c = 0; c < LW; c++) begin
        if (k < npix)
          send_pix(pix(mode, r, c), use_sof && (k == 0), gaps ? int'($urandom_range(0, 1)) : 0);
        k++;
      end
    end
  endtask

  task automatic drain(input string tag, input int exp_cnt);
    int n;
    n = 0;
    rdy_mode = 1;
    while ((exp_q.size() != 0 || valid_o) && n < 50) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    check("drain_done", n < 50, 1);
    check(tag, out_cnt, exp_cnt);
    out_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_valid", valid_o, 0);
    check("rst_gx", gx_o, 0);
    check("rst_gy", gy_o, 0);
    check("rst_ready", ready_o, 1);
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;

    for (int f = 0; f < 4; f++) begin
      send_frame(0, 1'b1, 1'b0, LW * FH);
      drain("flat_cnt", 4);
      check("flat_gx", last_gx, 0);
      check("flat_gy", last_gy, 0);
    end

    send_frame(1, 1'b1, 1'b0, LW * FH);
    drain("vedge_cnt", 4);
    check("vedge_gx", last_gx, 255);
    check("vedge_gy", last_gy, 0);

    send_frame(2, 1'b1, 1'b0, LW * FH);
    drain("hedge_cnt", 4);
    check("hedge_gx", last_gx, 0);
    check("hedge_gy", last_gy, 40);

    for (int f = 0; f < 8; f++) begin
      rdy_mode = 2;
      send_frame(3, 1'b1, 1'b1, LW * FH);
      drain("rand_cnt", 4);
    end

    rdy_mode = 2;
    send_frame(3, 1'b1, 1'b1, LW + LW / 2);
    send_frame(3, 1'b1, 1'b1, LW * FH);
    drain("resync_cnt", 4);

    rdy_mode = 0;
    send_frame(3, 1'b1, 1'b0, 2 * LW + 3);
    @(negedge clk_i);
    check("pre_rst_valid", valid_o, 1);
    @(posedge clk_i);
    #1;
    rstn_i = 1'b0;
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    @(negedge clk_i);
    check("post_rst_valid", valid_o, 0);
    @(posedge clk_i);
    #1;
    out_cnt = 0;
    rdy_mode = 2;
    send_frame(3, 1'b0, 1'b1, LW * FH);
    drain("after_rst_cnt", 4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
